axi2apb_rd: RTL
===============

// Module: axi2apb_rd
// PURPOSE
//  AXI read-data return path of the AXI-to-APB bridge; companion to the write-response path.
//  Captures PRDATA/PSLVERR on each completed APB read and forms an AXI R beat (RID, RDATA, RRESP, RLAST).
//  Buffers beats in a small FIFO so RREADY back-pressure does not stall the APB side.
//  Signals burst completion to the bridge control block.
// PARAMETERS
//  ID_BITS    4   AXI ID width
//  DATA_BITS  32  APB/AXI data width
//  LEN_BITS   4   AXI ARLEN width (beats = len+1)
//  DEPTH      2   R beat buffer entries (power of 2, >=2)
// PORTS
//  clk        in   1          clock
//  reset      in   1          synchronous, active-high reset
//  cmd_start  in   1          1-cycle pulse: new read command accepted by control
//  cmd_id     in   ID_BITS    ARID of current command, valid on cmd_start
//  cmd_len    in   LEN_BITS   ARLEN of current command, valid on cmd_start
//  cmd_err    in   1          command decode error, held for whole command
//  rd_space   out  1          buffer can accept one more beat; control starts APB read only when high
//  finish_rd  out  1          last beat of burst accepted on R (RVALID&RREADY&RLAST)
//  psel, penable, pwrite, pready, pslverr  in  1  APB master-side status
//  prdata     in   DATA_BITS  APB read data
//  RID        out  ID_BITS    AXI R channel
//  RDATA      out  DATA_BITS
//  RRESP      out  2
//  RLAST      out  1
//  RVALID     out  1
//  RREADY     in   1
// BEHAVIOUR
//  - Codes: RESP_OK=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//  - push = psel & penable & ~pwrite & pready (APB read completion), one beat per push.
//  - Beat fields on push: RID=latched id; RRESP = cmd_err ? SLVERR : pslverr ? DECERR : OK;
//    RDATA = cmd_err ? 0 : prdata; RLAST = (beat_cnt == latched len).
//  - cmd_start: latch cmd_id/cmd_len, clear beat_cnt. push: beat_cnt++ (wraps only via cmd_start).
//    cmd_start and push in same cycle: push uses the OLD latched id/len/cnt, then new command loads.
//  - FIFO: DEPTH entries of {id,data,resp,last}; wr/rd pointers wrap mod DEPTH; count 0..DEPTH.
//    pop = RVALID & RREADY. Simultaneous push+pop: count unchanged, both pointers advance,
//    legal when full (pop frees the slot the same cycle).
//  - RVALID = (count != 0); R outputs driven combinationally from head entry; head stable while
//    RVALID & ~RREADY (AXI rule). Push into empty FIFO: RVALID high the next cycle (1-cycle latency).
//  - rd_space = (count < DEPTH); registered-state derived, no combinational path from RREADY.
//  - push while full & ~pop: control-protocol violation; beat dropped, simulation assertion fires.
//  - finish_rd = RVALID & RREADY & RLAST (combinational).
//  - Reset (any cycle, incl. mid-burst): count=0, pointers=0, beat_cnt=0, latched id/len=0;
//    hence RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, finish_rd=0, rd_space=1. Buffered beats discarded.
//  - Empty-FIFO outputs: RID/RDATA/RRESP/RLAST forced to 0 while RVALID=0.
// STRUCTURE
//  - Shared package/include: RESP_* codes, ID_BITS/DATA_BITS/LEN_BITS defaults, FFD delay constant.
//  - Sub-module axi2apb_rfifo: generic synchronous FIFO (WIDTH, DEPTH; push/pop/full/empty/count).
//  - Top: command latch, beat counter, beat formatting, flow-control outputs.
// TESTING
//  - Single beat: cmd_start id=3 len=0, APB read prdata=32'hA5A5_0001 -> next cycle RVALID=1,
//    RID=3, RDATA=A5A5_0001, RRESP=00, RLAST=1; RREADY=1 -> finish_rd pulse, RVALID drops.
//  - Burst len=3 with RREADY=1: 4 beats, RLAST only on 4th; pslverr on beat 2 -> RRESP=11 that beat only.
//  - Back-pressure: RREADY=0, 2 pushes -> rd_space=0, RVALID held, data stable;
//    RREADY=1 with simultaneous 3rd push -> count stays 2, order preserved.
//  - cmd_err=1, len=1, prdata=FFFF_FFFF -> both beats RRESP=10, RDATA=0, second RLAST=1.
//  - Reset asserted with 2 beats buffered mid-burst -> next cycle RVALID=0, rd_space=1,
//    all R outputs 0; new command after reset starts at beat 0.
//  - Back-to-back commands: cmd_start (id=5) coincident with last push of id=2 -> last beat RID=2,
//    following beats RID=5.

Source files
------------

// File: rtl/axi2apb_rd_pkg.sv
// ---------------------------------------------------------------------------
// axi2apb_rd_pkg
// Shared constants for the AXI read-data return path of the AXI-to-APB bridge.
//   RESP_*      : AXI RRESP encodings used by the bridge
//   *_DEF       : default widths/depth for axi2apb_rd and its R beat buffer
//   FFD_DELAY   : flop-to-output delay used by simulation benches when
//                 sampling outputs after an active clock edge
//   beatResp()  : RRESP selection for one captured APB read
// ---------------------------------------------------------------------------
package axi2apb_rd_pkg;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ID_BITS_DEF   = 4;
  localparam int DATA_BITS_DEF = 32;
  localparam int LEN_BITS_DEF  = 4;
  localparam int DEPTH_DEF     = 2;

  localparam int FFD_DELAY = 1;

  // A command that failed address decode reports SLVERR on every beat, even
  // if the APB side also flagged an error; otherwise an APB slave error is
  // reported to AXI as DECERR.
  function automatic logic [1:0] beatResp(input logic cmdErr, input logic slvErr);
    logic [1:0] resp;
    resp = RESP_OK;
    if (cmdErr) begin
      resp = RESP_SLVERR;
    end else if (slvErr) begin
      resp = RESP_DECERR;
    end
    return resp;
  endfunction

endpackage

// File: rtl/axi2apb_rd_rfifo.sv
// ---------------------------------------------------------------------------
// axi2apb_rfifo
// Generic synchronous FIFO used as the R beat buffer.
//   clk, reset : clock, synchronous active-high reset
//   i_push     : write i_wdata (ignored when full unless i_pop is also high)
//   i_pop      : discard head entry (ignored when empty)
//   i_wdata    : entry to write
//   o_rdata    : head entry (combinational from storage)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module axi2apb_rfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_wrEn;
  logic             w_rdEn;

  // A push into a full buffer is only accepted when the head is popped in the
  // same cycle; the write then lands in the slot being freed.
  assign w_wrEn  = i_push & (~o_full | i_pop);
  assign w_rdEn  = i_pop & ~o_empty;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rdPtr];

  // Storage is deliberately not reset: entries are only observed while the
  // count says they are valid.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers and occupancy; simultaneous write and read leaves the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_rdEn) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_wrEn, w_rdEn})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi2apb_rd.sv
// ---------------------------------------------------------------------------
// axi2apb_rd
// AXI read-data return path of the AXI-to-APB bridge. Each completed APB read
// becomes one AXI R beat, buffered so RREADY back-pressure never stalls APB.
//   clk, reset        : clock, synchronous active-high reset
//   cmd_start         : 1-cycle pulse, new read command accepted by control
//   cmd_id, cmd_len   : ARID / ARLEN of the new command, valid on cmd_start
//   cmd_err           : command decode error, held for the whole command
//   rd_space          : buffer can take one more beat (gates new APB reads)
//   finish_rd         : last beat of the burst accepted on R
//   psel, penable, pwrite, pready, pslverr, prdata : APB master-side status
//   RID, RDATA, RRESP, RLAST, RVALID, RREADY       : AXI R channel
// ---------------------------------------------------------------------------
module axi2apb_rd
  import axi2apb_rd_pkg::*;
#(
  parameter int ID_BITS   = ID_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic [ID_BITS-1:0]   cmd_id,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic                 cmd_err,
  output logic                 rd_space,
  output logic                 finish_rd,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic                 pready,
  input  logic                 pslverr,
  input  logic [DATA_BITS-1:0] prdata,
  output logic [ID_BITS-1:0]   RID,
  output logic [DATA_BITS-1:0] RDATA,
  output logic [1:0]           RRESP,
  output logic                 RLAST,
  output logic                 RVALID,
  input  logic                 RREADY
);

  localparam int ENTRY_W = ID_BITS + DATA_BITS + 2 + 1;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ID_BITS-1:0]   r_id;
  logic [LEN_BITS-1:0]  r_len;
  logic [LEN_BITS-1:0]  r_beatCnt;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [CNT_W-1:0]     w_count;
  logic [ENTRY_W-1:0]   w_wrEntry;
  logic [ENTRY_W-1:0]   w_head;
  logic [ID_BITS-1:0]   w_headId;
  logic [DATA_BITS-1:0] w_headData;
  logic [1:0]           w_headResp;
  logic                 w_headLast;
  logic [DATA_BITS-1:0] w_beatData;
  logic                 w_beatLast;

  assign w_push = psel & penable & ~pwrite & pready;
  assign w_pop  = RVALID & RREADY;

  // Beat formatting uses the currently latched command, so a push coincident
  // with cmd_start still belongs to the previous command.
  assign w_beatData = cmd_err ? '0 : prdata;
  assign w_beatLast = (r_beatCnt == r_len);
  assign w_wrEntry  = {r_id, w_beatData, beatResp(cmd_err, pslverr), w_beatLast};

  // Command latch and beat counter; cmd_start is applied after the increment
  // so it wins when both happen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id      <= '0;
      r_len     <= '0;
      r_beatCnt <= '0;
    end else begin
      if (w_push) begin
        r_beatCnt <= r_beatCnt + LEN_BITS'(1);
      end
      if (cmd_start) begin
        r_id      <= cmd_id;
        r_len     <= cmd_len;
        r_beatCnt <= '0;
      end
    end
  end

  axi2apb_rfifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_rfifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wrEntry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_headId, w_headData, w_headResp, w_headLast} = w_head;

  // R outputs come straight from the head entry and are held at zero while
  // the buffer is empty so stale storage never reaches the AXI side.
  assign RVALID    = ~w_empty;
  assign RID       = RVALID ? w_headId   : '0;
  assign RDATA     = RVALID ? w_headData : '0;
  assign RRESP     = RVALID ? w_headResp : RESP_OK;
  assign RLAST     = RVALID ? w_headLast : 1'b0;
  assign finish_rd = RVALID & RREADY & RLAST;

  // Derived from the registered count only, so RREADY never feeds the APB
  // control path combinationally.
  assign rd_space = (w_count < CNT_W'(DEPTH));

  // Control must never start an APB read without space; a push into a full
  // buffer without a pop is dropped by the FIFO and flagged here.
  assert property (@(posedge clk) disable iff (reset) !(w_push && w_full && !w_pop));

endmodule
